// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver and the host side.
// Latency: a byte written at edge N is visible on rd_data/rd_valid in cycle N+1 (first-word fall-through).
// Backpressure: none toward the receiver. A byte that arrives while full with no pop is dropped and sets a sticky overflow flag.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   wr_data, wr_valid   byte from the receiver, single-cycle pulse, never stalled
//   rd_data, rd_valid   head entry (zero when empty) and non-empty flag
//   rd_ready            consumer pops the head when rd_valid is high
//   level               stored entries, 0..DEPTH
//   almost_full, full   level >= AF_THRESH, level == DEPTH
//   overflow, ovf_clr   sticky drop flag and its synchronous clear
//   flush               synchronous empty; overrides push and pop
module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       full,
  output logic                       overflow,
  input  logic                       ovf_clr,
  input  logic                       flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF    = LVL_W'(AF_THRESH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;

  logic w_pop;
  logic w_push;
  logic w_drop;

  // All status flags come straight from the registered level counter, so they
  // move together one edge after the cause and never see wr_valid directly.
  assign rd_valid    = (r_level != '0);
  assign full        = (r_level == LVL_DEPTH);
  assign almost_full = (r_level >= LVL_AF);
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign rd_data     = rd_valid ? r_mem[r_rptr] : '0;

  // A pop in the same cycle frees the slot, so a write while full is still accepted.
  assign w_pop  = rd_valid & rd_ready;
  assign w_push = wr_valid & (~full | w_pop);
  // A byte discarded by flush is not a drop.
  assign w_drop = wr_valid & full & ~w_pop & ~flush;

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop in the same cycle as ovf_clr leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus randomized stimulus for uart_rx_fifo against a queue reference model.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: rd_ready is driven per step by the stimulus.
module tb_uart_rx_fifo;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int AF_THRESH = 12;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [4:0]        level;
  logic              almost_full;
  logic              full;
  logic              overflow;
  logic              ovf_clr;
  logic              flush;

  int errors = 0;
  int checks = 0;

  // Reference model: byte queue plus sticky flag.
  logic [7:0] mq[$];
  logic       movf;

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .level       (level),
    .almost_full (almost_full),
    .full        (full),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".rd_valid"},    32'(rd_valid),    32'(n != 0));
    chk({tag, ".rd_data"},     32'(rd_data),     (n != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, ".level"},       32'(level),       32'(n));
    chk({tag, ".full"},        32'(full),        32'(n == DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF_THRESH));
    chk({tag, ".overflow"},    32'(overflow),    32'(movf));
  endtask

  // One clock of stimulus: the model advances from the pre-edge state, then
  // every output is compared after the edge.
  task automatic step(input string tag, input logic w, input logic [7:0] d, input logic r,
                      input logic fl = 1'b0, input logic clr = 1'b0);
    logic was_full, pop, drop;
    wr_valid = w;
    wr_data  = d;
    rd_ready = r;
    flush    = fl;
    ovf_clr  = clr;
    was_full = (mq.size() == DEPTH);
    pop      = (mq.size() != 0) && r;
    if (fl) begin
      mq.delete();
      if (clr) movf = 1'b0;
    end else begin
      drop = w && was_full && !pop;
      if (pop) void'(mq.pop_front());
      if (w && !drop) mq.push_back(d);
      if (drop) movf = 1'b1;
      else if (clr) movf = 1'b0;
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    ovf_clr  = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int pushed;
    int guard;
    logic w, r;
    logic [7:0] b;

    rst_n = 1'b0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    ovf_clr = 1'b0; flush = 1'b0;
    mq.delete(); movf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push then pop.
    step("push_a5", 1'b1, 8'hA5, 1'b0);
    chk("push_a5.data_const", 32'(rd_data), 32'h0000_00A5);
    step("pop_a5", 1'b0, 8'h00, 1'b1);
    chk("pop_a5.level_const", 32'(level), 32'd0);

    // Fill 0x00..0x0F, drop 0xFF, drain in order.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0);
    step("drop_ff", 1'b1, 8'hFF, 1'b0);
    chk("drop_ff.ovf_const", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.order", 32'(rd_data), 32'(i));
      step("drain", 1'b0, 8'h00, 1'b1);
    end
    step("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Wrap-around: 40 incrementing bytes, level kept in 1..5.
    pushed = 0;
    guard  = 0;
    while ((pushed < 40 || mq.size() != 0) && guard < 1000) begin
      w = (pushed < 40) && (mq.size() < 5) && ($urandom_range(0, 3) != 0);
      r = ((mq.size() > 1) || (pushed == 40)) && ($urandom_range(0, 1) == 1);
      step("wrap", w, 8'(pushed + 8'h40), r);
      if (w) pushed++;
      guard++;
    end
    chk("wrap.completed", 32'(guard < 1000), 32'd1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 8'($urandom), 1'b0);
    step("full_pushpop", 1'b1, 8'h77, 1'b1);
    chk("full_pushpop.ovf_const", 32'(overflow), 32'd0);
    while (mq.size() > 1) step("drain2", 1'b0, 8'h00, 1'b1);
    chk("drain2.last_77", 32'(rd_data), 32'h77);
    step("drain2_last", 1'b0, 8'h00, 1'b1);

    // Empty with simultaneous push and pop.
    step("empty_pushpop", 1'b1, 8'h5C, 1'b1);
    chk("empty_pushpop.level_const", 32'(level), 32'd1);
    step("empty_pop", 1'b0, 8'h00, 1'b1);

    // Flush with 5 entries and overflow set.
    for (int i = 0; i < DEPTH; i++) step("fill3", 1'b1, 8'($urandom), 1'b0);
    step("drop3", 1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) step("pop3", 1'b0, 8'h00, 1'b1);
    step("flush_wr", 1'b1, 8'h33, 1'b0, 1'b1);
    chk("flush_wr.ovf_const", 32'(overflow), 32'd1);
    step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Drop and clear in the same cycle: drop wins.
    for (int i = 0; i < DEPTH; i++) step("fill4", 1'b1, 8'($urandom), 1'b0);
    step("drop_clr", 1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("drop_clr.ovf_const", 32'(overflow), 32'd1);
    step("flush4", 1'b0, 8'h00, 1'b1, 1'b1);

    // Asynchronous reset with 9 entries, between edges.
    for (int i = 0; i < 9; i++) step("fill5", 1'b1, 8'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    mq.delete(); movf = 1'b0;
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    b = 8'($urandom);
    step("post_rst_push", 1'b1, b, 1'b0);
    step("post_rst_pop", 1'b0, 8'h00, 1'b1);

    // Randomized soak against the model.
    for (int i = 0; i < 300; i++) begin
      step("soak", $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
